cic_decim_iq: RTL and testbench
===============================

# cic_decim_iq

Parametrised dual-channel (I/Q) CIC decimator for the receive DDC path. It sits between the NCO mixer and the compensating FIR. It generalises the fixed 4-stage decimator in three ways: stage count, widths and maximum rate are parameters; gain is a saturating arithmetic shift; the output uses a valid/ready handshake with a sticky overflow flag. Input samples may arrive with gaps (`in_valid` gating).

## Interface
- `IN_WIDTH`, 16, signed input width per channel
- `OUT_WIDTH`, 16, signed output width per channel
- `NUM_STAGES`, 4, integrator/comb stage count N (1..8)
- `MAX_RATE`, 160, largest decimation ratio
- `RATE_WIDTH`, 8, width of `rate`; must hold `MAX_RATE`
- `GAIN_WIDTH`, 6, width of `gain`
- Derived: `ACC_W` = `IN_WIDTH` + N·clog2(`MAX_RATE`)

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high
- `rate`  in  `RATE_WIDTH`  decimation ratio R
- `gain`  in  `GAIN_WIDTH`  right-shift amount applied to the comb output
- `in_i`, `in_q`  in  `IN_WIDTH`  signed samples
- `in_valid`  in  1  sample accepted on each clock where high
- `out_i`, `out_q`  out  `OUT_WIDTH`  signed decimated samples
- `out_valid`  out  1  output holds a sample
- `out_ready`  in  1  consumer accepts the sample
- `overflow`  out  1  sticky: a decimated sample was dropped
- `clear_overflow`  in  1  clears `overflow`

## Operation
- **Reset:** all integrators, combs, delay lines and the decimation counter go to 0. `rate_r` takes the clamped `rate`. All outputs are 0.
- **Integrators:**
  - On each cycle with `in_valid`, all N stages update together: stage 1 += input; stage k += registered stage k-1.
  - All stages are `ACC_W` bits, sign-extended input, two's-complement wrap (wrap is required).
  - Without `in_valid`, all stages hold.
- **Rate:**
  - `rate_r` = clamp(`rate`, 2, `MAX_RATE`).
  - `rate_r` is resampled only at reset and at each decimation boundary. A mid-period change therefore takes effect from the next period.
- **Decimation counter:**
  - Counts accepted inputs from 0 to `rate_r`-1.
  - The accepted input at count `rate_r`-1 wraps the counter to 0 and raises `dec_stb` on the next cycle.
- **Combs:**
  - Pipelined, one stage per clock, advanced only by the `dec_stb` token.
  - Stage k output = in − delay_k; delay_k is updated with in when the token passes.
  - `ACC_W` wide, wrapping.
- **Gain/saturation (one register stage):**
  - v = comb_N >>> `gain` (arithmetic shift, floor).
  - v > 2^(`OUT_WIDTH`-1)−1 → max; v < −2^(`OUT_WIDTH`-1) → min.
  - `gain` ≥ `ACC_W` yields 0 or −1.
  - I and Q are saturated independently.
- **Output handshake:**
  - A new sample loads the output register when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 in the same cycle (replace).
  - If `out_valid`=1 and `out_ready`=0 when a new sample arrives: the new sample is dropped, the held sample is kept, and `overflow` is set.
  - `out_valid` clears on `out_ready` when no new sample arrives that cycle.
- **overflow:** set takes priority over a simultaneous `clear_overflow`. It is cleared only by `clear_overflow` or `reset`.

## Timing
- **Latency:** the accepted input completing a period is at edge 0.
  - `dec_stb` is high in cycle 1.
  - Comb stage k is registered at edge 1+k.
  - `out_valid` rises at edge N+2 (N=4: 6 cycles).
- **Throughput:** one output per `rate_r` accepted inputs. With `rate_r` ≥ 2 the comb pipeline never holds two tokens in one stage.
- **Gain:** `gain` is sampled combinationally in the gain stage and may change at any time.
- **Reset mid-operation:**
  - In-flight samples are discarded; `out_valid` drops immediately (async).
  - After reset the first output appears after `rate_r` accepted inputs.
  - The output carries the normal CIC start-up transient for the first N outputs.

## Test plan
- **Reset:** assert `reset` mid-stream with `out_valid`=1 → `out_valid`, `out_i`, `out_q` and `overflow` are 0 asynchronously. After release with `rate`=4 and continuous input, the first `out_valid` follows the 4th accepted input by N+2 cycles.
- **DC gain:** N=4, `rate`=4, `gain`=0, `in_i`=1, `in_q`=−1, `in_valid`=1, `out_ready`=1 → after the transient, `out_i`=256 and `out_q`=−256. `out_valid` pulses once every 4 cycles.
- **Shift and saturation:** `rate`=160, `in_i`=100, `in_q`=−100.
  - `gain`=24 → `out_i`=3906, `out_q`=−3907.
  - `gain`=0 → `out_i`=32767, `out_q`=−32768.
- **Backpressure:** `rate`=4, `out_ready`=0 for 10 cycles → the first sample is held unchanged and the second is dropped; `overflow`=1.
  - `clear_overflow` pulsed together with a further drop → `overflow` stays 1.
  - `clear_overflow` pulsed alone → `overflow`=0.
- **Rate change:** `rate` changed from 4 to 8 when the counter is at 2 → the next output follows 2 more inputs, then outputs are spaced every 8. Steady DC output with input 1 and `gain`=0 is 4096.
  - `rate`=0 → behaves as 2.
  - `rate`=255 → behaves as 160.
- **Gapped input:** as the DC-gain case but with `in_valid` at 50% duty → identical output sequence, spaced every 8 cycles.

Source files
------------

// File: rtl/cic_decim_iq.sv
// rtl/cic_decim_iq.sv - dual-channel (I/Q) CIC decimator with saturating gain and valid/ready output
// Pipelined integrators at input rate, token-driven comb pipeline, sticky overflow on dropped samples.
module cic_decim_iq #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_STAGES = 4,
  parameter int MAX_RATE   = 160,
  parameter int RATE_WIDTH = 8,
  parameter int GAIN_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [RATE_WIDTH-1:0]       rate,
  input  logic [GAIN_WIDTH-1:0]       gain,
  input  logic signed [IN_WIDTH-1:0]  in_i,
  input  logic signed [IN_WIDTH-1:0]  in_q,
  input  logic                        in_valid,
  output logic signed [OUT_WIDTH-1:0] out_i,
  output logic signed [OUT_WIDTH-1:0] out_q,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int N     = NUM_STAGES;
  localparam int ACC_W = IN_WIDTH + N * $clog2(MAX_RATE);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t OUT_MAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam acc_t OUT_MIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  acc_t                  integ_q [2][N];
  acc_t                  integ_d [2][N];
  acc_t                  in_ext  [2];
  logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATE_WIDTH-1:0] rate_r_q, rate_r_d;
  logic [RATE_WIDTH-1:0] rate_clamped;
  logic                  dec_stb_q, dec_stb_d;

  // stage index 0 holds the sampled integrator output; 1..N are the combs
  acc_t                  stage_q [2][N+1];
  acc_t                  stage_d [2][N+1];
  acc_t                  dly_q   [2][N];
  acc_t                  dly_d   [2][N];
  logic [N:0]            tok_q, tok_d;

  acc_t                  shifted [2];
  logic signed [OUT_WIDTH-1:0] sat   [2];
  logic signed [OUT_WIDTH-1:0] dout_q [2];
  logic signed [OUT_WIDTH-1:0] dout_d [2];
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;

  always_comb begin
    rate_clamped = rate;
    if (rate < RATE_WIDTH'(2)) begin
      rate_clamped = RATE_WIDTH'(2);
    end else if (rate > RATE_WIDTH'(MAX_RATE)) begin
      rate_clamped = RATE_WIDTH'(MAX_RATE);
    end
  end

  always_comb begin
    in_ext[0] = acc_t'(in_i);
    in_ext[1] = acc_t'(in_q);
    integ_d   = integ_q;
    cnt_d     = cnt_q;
    rate_r_d  = rate_r_q;
    dec_stb_d = 1'b0;
    if (in_valid) begin
      for (int c = 0; c < 2; c++) begin
        integ_d[c][0] = integ_q[c][0] + in_ext[c];
        for (int k = 1; k < N; k++) begin
          integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
        end
      end
      if (cnt_q == rate_r_q - RATE_WIDTH'(1)) begin
        cnt_d     = '0;
        dec_stb_d = 1'b1;
        rate_r_d  = rate_clamped;
      end else begin
        cnt_d = cnt_q + RATE_WIDTH'(1);
      end
    end
  end

  always_comb begin
    stage_d  = stage_q;
    dly_d    = dly_q;
    tok_d[0] = dec_stb_q;
    for (int c = 0; c < 2; c++) begin
      if (dec_stb_q) begin
        stage_d[c][0] = integ_q[c][N-1];
      end
    end
    for (int k = 1; k <= N; k++) begin
      tok_d[k] = tok_q[k-1];
      for (int c = 0; c < 2; c++) begin
        if (tok_q[k-1]) begin
          stage_d[c][k] = stage_q[c][k-1] - dly_q[c][k-1];
          dly_d[c][k-1] = stage_q[c][k-1];
        end
      end
    end
  end

  // shift by >= ACC_W collapses to the sign, i.e. 0 or -1
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      shifted[c] = stage_q[c][N] >>> gain;
      if (shifted[c] > OUT_MAX) begin
        sat[c] = OUT_MAX[OUT_WIDTH-1:0];
      end else if (shifted[c] < OUT_MIN) begin
        sat[c] = OUT_MIN[OUT_WIDTH-1:0];
      end else begin
        sat[c] = shifted[c][OUT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
    end
    if (tok_q[N]) begin
      if (!out_valid_q || out_ready) begin
        dout_d      = sat;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      integ_q     <= '{default: '0};
      cnt_q       <= '0;
      rate_r_q    <= rate_clamped;
      dec_stb_q   <= 1'b0;
      stage_q     <= '{default: '0};
      dly_q       <= '{default: '0};
      tok_q       <= '0;
      dout_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      cnt_q       <= cnt_d;
      rate_r_q    <= rate_r_d;
      dec_stb_q   <= dec_stb_d;
      stage_q     <= stage_d;
      dly_q       <= dly_d;
      tok_q       <= tok_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_i     = dout_q[0];
  assign out_q     = dout_q[1];
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cic_decim_iq.sv
// tb/tb_cic_decim_iq.sv - directed bench for cic_decim_iq (N=4, 16-bit I/Q)
// Expected values are hand-derived steady-state CIC gains R^N * x and handshake timings.
module tb_cic_decim_iq;

  logic               clk = 1'b0;
  logic               reset;
  logic [7:0]         rate;
  logic [5:0]         gain;
  logic signed [15:0] in_i, in_q;
  logic               in_valid;
  logic signed [15:0] out_i, out_q;
  logic               out_valid;
  logic               out_ready;
  logic               overflow;
  logic               clear_overflow;

  logic valid_base = 1'b1;
  logic gap_mode   = 1'b0;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  int ot, oi, oq, e, r, t0;

  cic_decim_iq dut (
    .clk(clk), .reset(reset), .rate(rate), .gain(gain),
    .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      in_valid = gap_mode ? ~in_valid : valid_base;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (out_valid !== 1'b1 && k < 1000);
    if (out_valid !== 1'b1) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed no out_valid expected out_valid within 1000 cycles", tag);
    end
    ot = cyc;
    oi = out_i;
    oq = out_q;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) wait_out("skip");
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rate = 8'd4; gain = 6'd0;
    in_i = 16'sd1; in_q = -16'sd1;
    out_ready = 1'b1; clear_overflow = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_out_i", out_i, 0);
    check("rst_ovf", overflow, 0);

    // DC gain, rate 4: first output 6 cycles after the 4th accepted input
    reset = 1'b0; r = cyc;
    wait_out("first_out");
    check("first_out_time", ot, r + 10);
    skip(4);
    wait_out("dc4"); t0 = ot;
    check("dc4_i", oi, 256);
    check("dc4_q", oq, -256);
    wait_out("dc4_b");
    check("dc4_gap", ot - t0, 4);
    check("dc4_b_i", oi, 256);

    // gapped input at 50% duty
    gap_mode = 1'b1;
    skip(2);
    wait_out("gap"); t0 = ot;
    wait_out("gap_b");
    check("gap_spacing", ot - t0, 8);
    check("gap_i", oi, 256);
    check("gap_q", oq, -256);
    gap_mode = 1'b0;

    // backpressure: hold first, drop second, overflow sticky
    skip(2);
    wait_out("bp"); e = ot;
    @(negedge clk);
    out_ready = 1'b0;
    wait_cyc(e + 7);
    check("bp_held_valid", out_valid, 1);
    check("bp_no_ovf_yet", overflow, 0);
    wait_cyc(e + 8);
    check("bp_ovf_set", overflow, 1);
    wait_cyc(e + 11);
    check("bp_held_i", out_i, 256);
    check("bp_held_q", out_q, -256);
    clear_overflow = 1'b1;
    wait_cyc(e + 12);
    check("bp_set_beats_clear", overflow, 1);
    wait_cyc(e + 13);
    clear_overflow = 1'b0;
    check("bp_clear", overflow, 0);
    check("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_cyc(e + 14);
    check("bp_valid_drop", out_valid, 0);

    // shift and saturation, rate 160
    rate = 8'd160; gain = 6'd24; in_i = 16'sd100; in_q = -16'sd100;
    skip(7);
    wait_out("sh24"); t0 = ot;
    check("sh24_i", oi, 3906);
    check("sh24_q", oq, -3907);
    gain = 6'd0;
    wait_out("sat");
    check("sat_gap", ot - t0, 160);
    check("sat_i", oi, 32767);
    check("sat_q", oq, -32768);

    // rate 255 clamps to 160
    rate = 8'd255; gain = 6'd24;
    wait_out("r255"); t0 = ot;
    wait_out("r255_b");
    check("r255_gap", ot - t0, 160);
    check("r255_i", oi, 3906);

    // rate change 4 -> 8 with the counter at 2
    rate = 8'd4; gain = 6'd0; in_i = 16'sd1; in_q = -16'sd1;
    skip(8);
    wait_out("rc"); e = ot;
    check("rc_pre_i", oi, 256);
    rate = 8'd8;
    wait_out("rc1"); check("rc_t1", ot - e, 4);
    wait_out("rc2"); check("rc_t2", ot - e, 8);
    wait_out("rc3"); check("rc_t3", ot - e, 16);
    wait_out("rc4"); check("rc_t4", ot - e, 24);
    skip(4);
    wait_out("rc8"); t0 = ot;
    wait_out("rc8_b");
    check("rc8_gap", ot - t0, 8);
    check("rc8_i", oi, 4096);
    check("rc8_q", oq, -4096);

    // rate 0 clamps to 2
    rate = 8'd0;
    skip(10);
    wait_out("r0"); t0 = ot;
    wait_out("r0_b");
    check("r0_gap", ot - t0, 2);
    check("r0_i", oi, 16);
    check("r0_q", oq, -16);

    // asynchronous reset mid-stream with a held sample and overflow set
    out_ready = 1'b0;
    wait_out("pre_rst"); e = ot;
    wait_cyc(e + 6);
    check("pre_rst_ovf", overflow, 1);
    rate = 8'd4;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_out_i", out_i, 0);
    check("arst_out_q", out_q, 0);
    check("arst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1; r = cyc;
    wait_out("post_rst");
    check("post_rst_time", ot, r + 10);
    wait_out("post_rst_b");
    check("post_rst_gap", ot - r, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
